// File: rtl/ucall_stack.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | ucall_stack : circular microcode call/return stack (push/pop/replace).    |
// | Optional sticky overflow/underflow flags under macro USTACK_ERR_EN.       |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module ucall_stack #(
  parameter int DEPTH  = 16,
  parameter int AWIDTH = 12,
  parameter int PTRW   = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clken,
  input  logic              call,
  input  logic              ret,
  input  logic [AWIDTH-1:0] addrIN,
  output logic [AWIDTH-1:0] addrOUT,
  output logic [PTRW:0]     level,
  output logic              empty,
  output logic              full,
  output logic [1:0]        err
);

  localparam logic [PTRW:0]   c_lvl_full = (PTRW+1)'(DEPTH);
  localparam logic [PTRW:0]   c_lvl_one  = (PTRW+1)'(1);
  localparam logic [PTRW-1:0] c_sp_one   = PTRW'(1);

  logic [AWIDTH-1:0] mem_q [DEPTH];
  logic [AWIDTH-1:0] mem_d [DEPTH];
  logic [PTRW-1:0]   sp_q, sp_d;
  logic [PTRW:0]     level_q, level_d;
  logic [PTRW-1:0]   w_top_idx;
  logic              w_push, w_pop, w_repl;

  assign w_top_idx = sp_q - c_sp_one;
  assign w_push    = clken &  call & ~ret;
  assign w_pop     = clken & ~call &  ret;
  assign w_repl    = clken &  call &  ret;

  assign addrOUT = mem_q[w_top_idx];
  assign level   = level_q;
  assign empty   = (level_q == '0);
  assign full    = (level_q == c_lvl_full);

  always_comb begin
    mem_d   = mem_q;
    sp_d    = sp_q;
    level_d = level_q;
    if (w_push) begin
      // A push while full silently overwrites the oldest entry.
      mem_d[sp_q] = addrIN;
      sp_d        = sp_q + c_sp_one;
      if (!full) level_d = level_q + c_lvl_one;
    end else if (w_pop) begin
      sp_d = w_top_idx;
      if (!empty) level_d = level_q - c_lvl_one;
    end else if (w_repl) begin
      // Page fail during a return: the top entry is swapped in place.
      mem_d[w_top_idx] = addrIN;
      if (empty) level_d = c_lvl_one;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      sp_q    <= '0;
      level_q <= '0;
    end else begin
      mem_q   <= mem_d;
      sp_q    <= sp_d;
      level_q <= level_d;
    end
  end

`ifdef USTACK_ERR_EN
  logic [1:0] err_q, err_d;

  assign err_d = err_q | {w_pop & empty, w_push & full};
  assign err   = err_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) err_q <= 2'b00;
    else      err_q <= err_d;
  end
`else
  assign err = 2'b00;
`endif

endmodule
`default_nettype wire
